// File: rtl/disp_scan_ctrl_pkg.sv
// rtl/disp_scan_ctrl_pkg.sv - scan FSM encodings, digit count and anode helpers
package disp_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } scan_state_t;

  localparam int         DIGITS = 4;
  localparam logic [3:0] AN_OFF = 4'hF;

  // Active-low one-hot anode for the given digit.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << idx;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_prescaler.sv
// rtl/disp_scan_ctrl_prescaler.sv - loadable up-counter timing both blank and on phases
module disp_scan_ctrl_prescaler #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inc,
  output logic             tc
);

  logic [WIDTH-1:0] cnt;

  // Phases end at all-ones, so a phase of N cycles loads 2^WIDTH - N.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (inc) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign tc = &cnt;

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 4-digit 7-segment scan controller with frame-synchronous score buffer
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = 17,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic [3:0]  blank_mask,
  output logic        load_ack,
  output logic [3:0]  AN,
  output logic [3:0]  hex_out,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  localparam int                  BLANK_START_I = (1 << SCAN_DIV) - BLANK_CYC;
  localparam logic [SCAN_DIV-1:0] BLANK_START   = BLANK_START_I[SCAN_DIV-1:0];
  localparam logic [1:0]          LAST_DIGIT    = 2'(DIGITS - 1);

  scan_state_t         state, state_n;
  logic [1:0]          idx, idx_n;
  logic [15:0]         shadow, shadow_n, pending, pending_n;
  logic                pend_valid, pend_valid_n;
  logic                ack_n, boundary, apply;
  logic [3:0]          an_n;
  logic                pre_clr, pre_ld, pre_inc, pre_tc;
  logic [SCAN_DIV-1:0] pre_ld_val;

  disp_scan_ctrl_prescaler #(.WIDTH(SCAN_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (pre_clr),
    .ld     (pre_ld),
    .ld_val (pre_ld_val),
    .inc    (pre_inc),
    .tc     (pre_tc)
  );

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    pre_clr    = 1'b0;
    pre_ld     = 1'b0;
    pre_ld_val = '0;
    pre_inc    = 1'b0;
    if (!en) begin
      state_n = S_OFF;
      idx_n   = 2'd0;
      pre_clr = 1'b1;
    end else begin
      case (state)
        S_OFF: begin
          state_n    = S_BLANK;
          pre_ld     = 1'b1;
          pre_ld_val = BLANK_START;
        end
        S_BLANK: begin
          if (pre_tc) begin
            state_n = S_ON;
            pre_ld  = 1'b1;
          end else begin
            pre_inc = 1'b1;
          end
        end
        S_ON: begin
          if (pre_tc) begin
            state_n    = S_BLANK;
            idx_n      = idx + 2'd1;
            pre_ld     = 1'b1;
            pre_ld_val = BLANK_START;
          end else begin
            pre_inc = 1'b1;
          end
        end
        default: state_n = S_OFF;
      endcase
    end
  end

  // Shadow only changes while dark: at the frame wrap or while the display is off.
  always_comb begin
    boundary     = en && (state == S_ON) && pre_tc && (idx == LAST_DIGIT);
    apply        = (state == S_OFF) || boundary;
    shadow_n     = shadow;
    pending_n    = pending;
    pend_valid_n = pend_valid;
    ack_n        = 1'b0;
    if (apply && load) begin
      shadow_n     = load_data;
      pend_valid_n = 1'b0;
      ack_n        = 1'b1;
    end else if (apply && pend_valid) begin
      shadow_n     = pending;
      pend_valid_n = 1'b0;
      ack_n        = 1'b1;
    end else if (load) begin
      pending_n    = load_data;
      pend_valid_n = 1'b1;
    end
    an_n = ((state_n == S_ON) && !blank_mask[idx_n]) ? anode_sel(idx_n) : AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_OFF;
      idx        <= 2'd0;
      shadow     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      AN         <= AN_OFF;
      hex_out    <= 4'd0;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      shadow     <= shadow_n;
      pending    <= pending_n;
      pend_valid <= pend_valid_n;
      AN         <= an_n;
      hex_out    <= shadow_n[{idx_n, 2'b00} +: 4];
      load_ack   <= ack_n;
      frame_tick <= boundary;
    end
  end

  assign digit_idx = idx;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - self-checking bench for disp_scan_ctrl
module tb_disp_scan_ctrl;

  localparam int SCAN_DIV  = 3;
  localparam int BLANK_CYC = 2;
  localparam int ON_CYC    = 1 << SCAN_DIV;
  localparam int PERIOD    = BLANK_CYC + ON_CYC;
  localparam int FRAME     = 4 * PERIOD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic        load_ack, frame_tick;
  logic [3:0]  AN, hex_out;
  logic [1:0]  digit_idx;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .load_data  (load_data),
    .blank_mask (blank_mask),
    .load_ack   (load_ack),
    .AN         (AN),
    .hex_out    (hex_out),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the frame as a plain cycle count.
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [15:0] m_shadow = 16'h0, m_pend = 16'h0;
  bit          m_pv = 1'b0;
  logic [3:0]  e_an = 4'hF, e_hex = 4'h0;
  logic [1:0]  e_idx = 2'd0;
  bit          e_ack = 1'b0, e_tick = 1'b0, e_hexv = 1'b0;

  task automatic model_edge();
    bit was_off, boundary, apply;
    int d;
    logic [3:0] sel;
    if (!rst) begin
      m_run = 1'b0; m_t = 0; m_shadow = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
      e_an = 4'hF; e_hex = 4'h0; e_idx = 2'd0; e_ack = 1'b0; e_tick = 1'b0; e_hexv = 1'b1;
    end else begin
      was_off  = !m_run;
      boundary = m_run && en && (m_t == FRAME - 1);
      apply    = was_off || boundary;
      e_ack    = 1'b0;
      if (apply && load) begin
        m_shadow = load_data; m_pv = 1'b0; e_ack = 1'b1;
      end else if (apply && m_pv) begin
        m_shadow = m_pend; m_pv = 1'b0; e_ack = 1'b1;
      end else if (load) begin
        m_pend = load_data; m_pv = 1'b1;
      end
      if (!en) begin
        m_run = 1'b0; m_t = 0;
      end else if (was_off) begin
        m_run = 1'b1; m_t = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
      e_tick = boundary;
      e_hexv = m_run;
      if (m_run) begin
        d     = m_t / PERIOD;
        e_idx = 2'(d);
        e_hex = m_shadow[4*d +: 4];
        sel   = 4'b0001 << d;
        e_an  = ((m_t % PERIOD) >= BLANK_CYC && !blank_mask[d]) ? ~sel : 4'hF;
      end else begin
        e_idx = 2'd0;
        e_an  = 4'hF;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_an", 16'(AN), 16'(e_an));
    chk("m_idx", 16'(digit_idx), 16'(e_idx));
    chk("m_ack", 16'(load_ack), 16'(e_ack));
    chk("m_tick", 16'(frame_tick), 16'(e_tick));
    if (e_hexv) chk("m_hex", 16'(hex_out), 16'(e_hex));
  endtask

  typedef struct {
    bit          r, e, l;
    logic [15:0] data;
    int          n;
    logic [3:0]  an, hex;
    logic [1:0]  idx;
    bit          ack, tick, chk_hex;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit l, logic [15:0] data, int n, logic [3:0] an,
                              logic [3:0] hex, logic [1:0] idx, bit ack, bit tick, bit chk_hex);
    vec_t v;
    v.r = r; v.e = e; v.l = l; v.data = data; v.n = n; v.an = an; v.hex = hex;
    v.idx = idx; v.ack = ack; v.tick = tick; v.chk_hex = chk_hex;
    return v;
  endfunction

  vec_t tbl[13];
  int   acks, ticks, last_tick, bad_an;
  bit   seen;

  initial begin
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 3, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    tbl[1]  = mk(1'b1, 1'b0, 1'b1, 16'h1234, 1, 4'hF, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 2, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 2, 4'hF, 4'h4, 2'd0, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 8, 4'hE, 4'h4, 2'd0, 1'b0, 1'b0, 1'b1);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 2, 4'hF, 4'h3, 2'd1, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 8, 4'hD, 4'h3, 2'd1, 1'b0, 1'b0, 1'b1);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 2, 4'hF, 4'h2, 2'd2, 1'b0, 1'b0, 1'b1);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 8, 4'hB, 4'h2, 2'd2, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 2, 4'hF, 4'h1, 2'd3, 1'b0, 1'b0, 1'b1);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 8, 4'h7, 4'h1, 2'd3, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1, 4'hF, 4'h4, 2'd0, 1'b0, 1'b1, 1'b1);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1, 4'hF, 4'h4, 2'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].r; en = tbl[i].e; load = tbl[i].l; load_data = tbl[i].data;
      for (int k = 0; k < tbl[i].n; k++) begin
        cycle();
        load = 1'b0;
        chk("t_an", 16'(AN), 16'(tbl[i].an));
        chk("t_idx", 16'(digit_idx), 16'(tbl[i].idx));
        chk("t_ack", 16'(load_ack), 16'(tbl[i].ack));
        chk("t_tick", 16'(frame_tick), 16'(tbl[i].tick));
        if (tbl[i].chk_hex) chk("t_hex", 16'(hex_out), 16'(tbl[i].hex));
      end
    end

    // Two loads mid-frame: old digits held, one ack at the frame wrap, latest wins.
    for (int k = 0; k < FRAME && m_t < BLANK_CYC + 1; k++) cycle();
    load = 1'b1; load_data = 16'hABCD; cycle(); load = 1'b0;
    acks = 0;
    for (int k = 0; k < 3; k++) begin cycle(); acks += int'(load_ack); end
    load = 1'b1; load_data = 16'h5678; cycle(); load = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 2 * FRAME && !seen; k++) begin
      cycle();
      acks += int'(load_ack);
      if (frame_tick) begin
        seen = 1'b1;
        chk("ack_with_tick", 16'(load_ack), 16'd1);
      end else if (digit_idx == 2'd0) begin
        chk("hold_hex", 16'(hex_out), 16'h4);
      end
    end
    chk("tick_seen", 16'(seen), 16'd1);
    for (int k = 0; k < 5; k++) begin cycle(); acks += int'(load_ack); end
    chk("single_ack", 16'(acks), 16'd1);
    chk("new_digit0_hex", 16'(hex_out), 16'h8);
    chk("new_digit0_an", 16'(AN), 16'hE);

    // Masked digit 2 never lights; tick spacing is one frame.
    blank_mask = 4'b0100;
    ticks = 0; last_tick = 0; bad_an = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      cycle();
      if (AN == 4'b1011) bad_an++;
      if (frame_tick) begin
        if (ticks > 0) chk("tick_spacing", 16'(k - last_tick), 16'(FRAME));
        ticks++;
        last_tick = k;
      end
    end
    chk("masked_an", 16'(bad_an), 16'd0);
    chk("tick_count", 16'(ticks), 16'd2);
    blank_mask = 4'h0;

    // Disable during digit 2 on-time with a load pending.
    for (int k = 0; k < FRAME && m_t != PERIOD + 3; k++) cycle();
    load = 1'b1; load_data = 16'h9ABC; cycle(); load = 1'b0;
    for (int k = 0; k < FRAME && m_t != 2 * PERIOD + BLANK_CYC + 2; k++) cycle();
    en = 1'b0; cycle();
    chk("off_an", 16'(AN), 16'hF);
    chk("off_idx", 16'(digit_idx), 16'd0);
    chk("off_no_ack", 16'(load_ack), 16'd0);
    cycle();
    chk("off_apply_ack", 16'(load_ack), 16'd1);
    en = 1'b1;
    for (int k = 0; k < BLANK_CYC; k++) begin
      cycle();
      chk("restart_blank_an", 16'(AN), 16'hF);
      chk("restart_idx", 16'(digit_idx), 16'd0);
    end
    cycle();
    chk("restart_on_an", 16'(AN), 16'hE);
    chk("restart_on_hex", 16'(hex_out), 16'hC);

    // Reset before the frame wrap drops the pending load without ack.
    for (int k = 0; k < FRAME && m_t != PERIOD + 3; k++) cycle();
    acks = 0;
    load = 1'b1; load_data = 16'h1111; cycle(); load = 1'b0;
    acks += int'(load_ack);
    for (int k = 0; k < 2; k++) begin cycle(); acks += int'(load_ack); end
    rst = 1'b0; cycle(); rst = 1'b1;
    chk("rst_hex", 16'(hex_out), 16'h0);
    for (int k = 0; k < 2 * FRAME; k++) begin cycle(); acks += int'(load_ack); end
    chk("no_ack_after_rst", 16'(acks), 16'd0);

    // Randomised run against the model.
    for (int k = 0; k < 1500; k++) begin
      rst       = ($urandom_range(0, 299) != 0);
      en        = ($urandom_range(0, 59) != 0);
      load      = ($urandom_range(0, 14) == 0);
      load_data = 16'($urandom);
      if ($urandom_range(0, 19) == 0) blank_mask = 4'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
